// File: rtl/pen_locator.sv
// pen_locator: single-pixel probe sweep over the 8x8 LED matrix with a
// light-pen hit decoder. A hit is confirmed over several frames and then
// reported as (x,y) on a valid/ack handshake.
module pen_locator #(
    parameter int DWELL   = 2000,
    parameter int SETTLE  = 500,
    parameter int MIN_HI  = 8,
    parameter int CONFIRM = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pen,
    input  logic       hit_ack,
    output logic [7:0] probe_row,
    output logic [7:0] probe_col,
    output logic [2:0] hit_x,
    output logic [2:0] hit_y,
    output logic       hit_valid,
    output logic       overrun,
    output logic       pen_present
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int RW = $clog2(MIN_HI + 1);
    localparam int CW = $clog2(CONFIRM + 1);

    localparam logic [DW-1:0] D_LAST   = DW'(DWELL - 1);
    localparam logic [DW-1:0] D_SETTLE = DW'(SETTLE);
    localparam logic [RW-1:0] RUN_HIT  = RW'(MIN_HI - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(MIN_HI);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CONFIRM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        EVAL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            pen_p0;
    logic            pen_p1;

    logic [5:0]      p;
    logic [DW-1:0]   d;
    logic [RW-1:0]   run;
    logic            fhit_vld;
    logic [5:0]      fhit;

    logic [5:0]      cand;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_new;

    logic            samp;
    logic            hit_now;
    logic            report;
    logic            busy;

    // Run length of synced-high samples, held once it reaches the threshold
    function automatic logic [RW-1:0] run_sat_inc(input logic [RW-1:0] v);
        return (v >= RUN_MAX) ? RUN_MAX : v + RW'(1);
    endfunction

    // Frame-confirmation count, held at CONFIRM
    function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CW'(1);
    endfunction

    // Two-flop synchronizer for the asynchronous pen input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pen_p0 <= 1'b0;
            pen_p1 <= 1'b0;
        end else begin
            pen_p0 <= pen;
            pen_p1 <= pen_p0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic; dropping en mid-sweep abandons the frame
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = SWEEP;
            SWEEP: begin
                if (!en)                              state_nxt = IDLE;
                else if (p == 6'd63 && d == D_LAST)   state_nxt = EVAL;
            end
            EVAL:    state_nxt = en ? SWEEP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: one lit pixel while sweeping, matrix dark otherwise
    always_comb begin
        probe_row = 8'hFF;
        probe_col = 8'h00;
        if (state == SWEEP) begin
            probe_row = ~(8'h01 << p[5:3]);
            probe_col = 8'h01 << p[2:0];
        end
    end

    // Sample window, hit detection and confirmation arithmetic
    always_comb begin
        samp    = (state == SWEEP) && (d >= D_SETTLE);
        hit_now = samp && pen_p1 && (run >= RUN_HIT);
        cnt_new = (fhit == cand) ? cnt_sat_inc(cnt) : CW'(1);
        report  = (state == EVAL) && fhit_vld && (cnt_new == CNT_MAX);
        busy    = hit_valid && !hit_ack;
    end

    // Pixel/dwell counters, pen run length and lowest-index hit of the frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p        <= '0;
            d        <= '0;
            run      <= '0;
            fhit_vld <= 1'b0;
            fhit     <= '0;
        end else if (state == SWEEP) begin
            if (d == D_LAST) begin
                d <= '0;
                p <= p + 6'd1;
            end else begin
                d <= d + DW'(1);
            end
            // Run restarts on every pixel change and outside the sample window
            if (d == D_LAST || !samp || !pen_p1) run <= '0;
            else                                 run <= run_sat_inc(run);
            if (hit_now && !fhit_vld) begin
                fhit_vld <= 1'b1;
                fhit     <= p;
            end
        end else begin
            p        <= '0;
            d        <= '0;
            run      <= '0;
            fhit_vld <= 1'b0;
        end
    end

    // Multi-frame confirmation, result handshake and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand        <= '0;
            cnt         <= '0;
            hit_x       <= '0;
            hit_y       <= '0;
            hit_valid   <= 1'b0;
            overrun     <= 1'b0;
            pen_present <= 1'b0;
        end else begin
            if (hit_ack && hit_valid) begin
                hit_valid <= 1'b0;
                overrun   <= 1'b0;
            end
            if (state == IDLE) begin
                cand <= '0;
                cnt  <= '0;
            end else if (state == EVAL) begin
                if (!fhit_vld) begin
                    pen_present <= 1'b0;
                    cnt         <= '0;
                end else begin
                    pen_present <= 1'b1;
                    cand        <= fhit;
                    if (report) begin
                        // Restart counting so a stationary pen reports periodically
                        cnt <= '0;
                        if (busy) begin
                            overrun <= 1'b1;
                        end else begin
                            hit_x     <= fhit[2:0];
                            hit_y     <= fhit[5:3];
                            hit_valid <= 1'b1;
                            overrun   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_new;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pen_locator.sv
// tb_pen_locator: frame-level stimulus for pen_locator with a small
// expected-result scoreboard and a few hand-written corner sequences.
module tb_pen_locator;

    localparam int DWELL   = 16;
    localparam int SETTLE  = 4;
    localparam int MIN_HI  = 3;
    localparam int CONFIRM = 2;
    localparam int SWEEP_CYC = 64 * DWELL;
    localparam int NV = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       pen = 1'b0;
    logic       hit_ack = 1'b0;
    logic [7:0] probe_row;
    logic [7:0] probe_col;
    logic [2:0] hit_x;
    logic [2:0] hit_y;
    logic       hit_valid;
    logic       overrun;
    logic       pen_present;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int pa; int sa; int la;
        int pb; int sb; int lb;
        bit ack_first; bit ack_eval;
        bit pp; bit hv; bit ov; int x; int y;
    } vec_t;

    typedef struct {
        bit pp; bit hv; bit ov; int x; int y;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb_q [$];

    pen_locator #(
        .DWELL(DWELL), .SETTLE(SETTLE), .MIN_HI(MIN_HI), .CONFIRM(CONFIRM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pen(pen), .hit_ack(hit_ack),
        .probe_row(probe_row), .probe_col(probe_col),
        .hit_x(hit_x), .hit_y(hit_y), .hit_valid(hit_valid),
        .overrun(overrun), .pen_present(pen_present)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(int pa, int sa, int la, int pb, int sb, int lb,
                                bit af, bit ae, bit pp, bit hv, bit ov, int x, int y);
        vec_t v;
        v.pa = pa; v.sa = sa; v.la = la;
        v.pb = pb; v.sb = sb; v.lb = lb;
        v.ack_first = af; v.ack_eval = ae;
        v.pp = pp; v.hv = hv; v.ov = ov; v.x = x; v.y = y;
        return v;
    endfunction

    function automatic bit pen_at(int c, vec_t v);
        int pix = c / DWELL;
        int dd  = c % DWELL;
        return (pix == v.pa && dd >= v.sa && dd < v.sa + v.la) ||
               (pix == v.pb && dd >= v.sb && dd < v.sb + v.lb);
    endfunction

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, want);
        end
    endtask

    // One full frame (sweep + EVAL); leaves the bench 1 time unit after the
    // edge that ends EVAL, inside cycle 0 of the next sweep.
    task automatic run_frame(input vec_t v, input bit chk_probe, input string tag);
        exp_t e;
        exp_t got;
        logic [7:0] rw;
        logic [7:0] cw;
        e.pp = v.pp; e.hv = v.hv; e.ov = v.ov; e.x = v.x; e.y = v.y;
        sb_q.push_back(e);
        for (int c = 0; c <= SWEEP_CYC; c++) begin
            @(negedge clk);
            pen     = (c < SWEEP_CYC) ? pen_at(c, v) : 1'b0;
            hit_ack = (v.ack_first && c == 0) || (v.ack_eval && c == SWEEP_CYC);
            if (chk_probe) begin
                if (c < SWEEP_CYC) begin
                    rw = ~(8'h01 << ((c / DWELL) / 8));
                    cw = 8'h01 << ((c / DWELL) % 8);
                end else begin
                    rw = 8'hFF;
                    cw = 8'h00;
                end
                check("probe_row", int'(probe_row), int'(rw));
                check("probe_col", int'(probe_col), int'(cw));
            end
        end
        @(posedge clk);
        #1;
        hit_ack = 1'b0;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 0, 1);
        end else begin
            got = sb_q.pop_front();
            check({tag, " pen_present"}, int'(pen_present), int'(got.pp));
            check({tag, " hit_valid"},   int'(hit_valid),   int'(got.hv));
            check({tag, " overrun"},     int'(overrun),     int'(got.ov));
            check({tag, " hit_x"},       int'(hit_x),       got.x);
            check({tag, " hit_y"},       int'(hit_y),       got.y);
        end
    endtask

    initial begin
        vec_t v30;
        // pa sa la  pb sb lb  ackF ackE  pp hv ov  x  y
        tbl[0]  = mk(-1, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(27, 6, 6, -1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(27, 6, 6, -1, 0, 0, 0, 0, 1, 1, 0, 3, 3);
        tbl[3]  = mk(-1, 0, 0, -1, 0, 0, 1, 0, 0, 0, 0, 3, 3);
        tbl[4]  = mk(10, 0, 4, -1, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        tbl[5]  = mk(10, 8, 2, -1, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        tbl[6]  = mk( 5, 6, 6, -1, 0, 0, 0, 0, 1, 0, 0, 3, 3);
        tbl[7]  = mk(40, 6, 6, -1, 0, 0, 0, 0, 1, 0, 0, 3, 3);
        tbl[8]  = mk(40, 6, 6, -1, 0, 0, 0, 0, 1, 1, 0, 0, 5);
        tbl[9]  = mk(12, 6, 6, 50, 6, 6, 1, 0, 1, 0, 0, 0, 5);
        tbl[10] = mk(12, 6, 6, -1, 0, 0, 0, 0, 1, 1, 0, 4, 1);
        tbl[11] = mk(20, 6, 6, -1, 0, 0, 1, 0, 1, 0, 0, 4, 1);
        tbl[12] = mk(20, 6, 6, -1, 0, 0, 0, 0, 1, 1, 0, 4, 2);
        tbl[13] = mk(20, 6, 6, -1, 0, 0, 0, 0, 1, 1, 0, 4, 2);
        tbl[14] = mk(20, 6, 6, -1, 0, 0, 0, 0, 1, 1, 1, 4, 2);
        tbl[15] = mk(-1, 0, 0, -1, 0, 0, 1, 0, 0, 0, 0, 4, 2);
        tbl[16] = mk(63, 10, 4, -1, 0, 0, 0, 0, 1, 0, 0, 4, 2);
        tbl[17] = mk(63, 10, 4, -1, 0, 0, 0, 0, 1, 1, 0, 7, 7);
        tbl[18] = mk( 9, 6, 6, -1, 0, 0, 0, 0, 1, 1, 0, 7, 7);
        tbl[19] = mk( 9, 6, 6, -1, 0, 0, 0, 0, 1, 1, 1, 7, 7);
        tbl[20] = mk( 9, 6, 6, -1, 0, 0, 0, 0, 1, 1, 1, 7, 7);
        tbl[21] = mk( 9, 6, 6, -1, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        tbl[22] = mk(-1, 0, 0, -1, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        tbl[23] = mk(-1, 0, 0, -1, 0, 0, 1, 0, 0, 0, 0, 1, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst probe_row", int'(probe_row), 8'hFF);
        check("rst probe_col", int'(probe_col), 0);
        check("rst hit_x", int'(hit_x), 0);
        check("rst hit_y", int'(hit_y), 0);
        check("rst hit_valid", int'(hit_valid), 0);
        check("rst overrun", int'(overrun), 0);
        check("rst pen_present", int'(pen_present), 0);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        for (int i = 0; i < NV; i++)
            run_frame(tbl[i], (i == 0), $sformatf("vec%0d", i));

        // en dropped mid-frame discards the candidate
        v30 = mk(30, 6, 6, -1, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        run_frame(v30, 1'b0, "p30_first");
        for (int c = 0; c <= 30 * DWELL + 8; c++) begin
            @(negedge clk);
            pen = pen_at(c, v30);
            if (c == 30 * DWELL + 8) begin
                check("drop probe_row_before", int'(probe_row), 8'hF7);
                check("drop probe_col_before", int'(probe_col), 8'h40);
                en = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        pen = 1'b0;
        check("drop probe_row", int'(probe_row), 8'hFF);
        check("drop probe_col", int'(probe_col), 0);
        check("drop pen_present_kept", int'(pen_present), 1);
        check("drop hit_valid", int'(hit_valid), 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        run_frame(v30, 1'b0, "p30_reenable1");
        v30.hv = 1'b1; v30.x = 6; v30.y = 3;
        run_frame(v30, 1'b0, "p30_reenable2");

        // Synchronous reset mid-sweep
        repeat (100) @(negedge clk);
        check("pre_rst probe_col_active", int'(probe_col != 8'h00), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst probe_row", int'(probe_row), 8'hFF);
        check("mid_rst probe_col", int'(probe_col), 0);
        check("mid_rst hit_x", int'(hit_x), 0);
        check("mid_rst hit_y", int'(hit_y), 0);
        check("mid_rst hit_valid", int'(hit_valid), 0);
        check("mid_rst overrun", int'(overrun), 0);
        check("mid_rst pen_present", int'(pen_present), 0);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
